// File: rtl/fast_core_data_arbiter.sv
// Arbitrates the onchip data RAM/SFR port between the fast core (priority) and a
// secondary debug/DMA requester; a starvation counter forces a one-cycle CPU stall.
module fast_core_data_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_read_addr,
    input  logic [15:0] cpu_write_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_read_addr,
    output logic [15:0] mem_write_addr,
    output logic [7:0]  mem_data_in,
    output logic        mem_we,
    input  logic [7:0]  mem_data_out
);

    typedef enum logic [1:0] {IDLE, DMA_ACCESS, DMA_ACK} state_t;

    state_t               state;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic                 acc_we;
    logic [7:0]           rdata_q;
    logic                 cpu_idle;
    logic                 sfr_hit;
    logic                 grant;
    logic                 rd_ok;

    assign cpu_idle = ~cpu_re & ~cpu_we;
    assign sfr_hit  = (dma_addr[15:8] == 8'h00) & dma_addr[7];
    assign grant    = dma_req & (cpu_idle | (wait_cnt == WAIT_BITS'(MAX_WAIT)));
    assign rd_ok    = (state == DMA_ACK) & ~acc_we & ~dma_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            acc_we   <= 1'b0;
            dma_ack  <= 1'b0;
            dma_err  <= 1'b0;
            rdata_q  <= 8'h00;
        end else begin
            dma_ack <= 1'b0;
            dma_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant)
                        state <= DMA_ACCESS;
                    else if (dma_req && wait_cnt != '1)
                        wait_cnt <= wait_cnt + 1'b1;
                end
                DMA_ACCESS: begin
                    // dma_we is latched so the ack cycle still knows the direction
                    // even if the requester drops dma_req early.
                    wait_cnt <= '0;
                    acc_we   <= dma_we;
                    dma_ack  <= 1'b1;
                    dma_err  <= sfr_hit;
                    state    <= DMA_ACK;
                end
                DMA_ACK: begin
                    if (rd_ok)
                        rdata_q <= mem_data_out;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM read data arrives during the ack cycle, so it bypasses the holding register.
    assign dma_rdata = rd_ok ? mem_data_out : rdata_q;
    assign cpu_stall = (state == DMA_ACCESS);

    always_comb begin
        mem_read_addr  = cpu_read_addr;
        mem_write_addr = cpu_write_addr;
        mem_data_in    = cpu_data_in;
        mem_we         = cpu_we;
        if (state == DMA_ACCESS) begin
            mem_read_addr  = dma_addr;
            mem_write_addr = dma_addr;
            mem_data_in    = dma_wdata;
            mem_we         = dma_we & ~sfr_hit;
        end
        if (!reset_n)
            mem_we = 1'b0;
    end

endmodule

// File: tb/tb_fast_core_data_arbiter.sv
// Randomized bench for fast_core_data_arbiter: a cycle-level reference model with
// its own RAM image predicts every output; directed cases cover the key scenarios.
module tb_fast_core_data_arbiter;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_read_addr, cpu_write_addr, dma_addr;
    logic [7:0]  cpu_data_in, dma_wdata;
    logic        cpu_we, cpu_re, dma_req, dma_we;
    logic        cpu_stall, dma_ack, dma_err, mem_we;
    logic [7:0]  dma_rdata, mem_data_in;
    logic [7:0]  mem_data_out = 8'h00;
    logic [15:0] mem_read_addr, mem_write_addr;

    always #5 clk = ~clk;

    fast_core_data_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_read_addr(cpu_read_addr), .cpu_write_addr(cpu_write_addr),
        .cpu_data_in(cpu_data_in), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out)
    );

    // RAM as seen by the DUT (1-cycle read latency, read-before-write)
    logic [7:0] tb_mem  [0:65535];
    logic [7:0] ref_mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_write_addr] <= mem_data_in;
        mem_data_out <= tb_mem[mem_read_addr];
    end

    int nchk = 0, nbad = 0;
    // reference model: phase 0 = waiting/idle, 1 = secondary owns the port, 2 = ack
    int         ph = 0, wcnt = 0;
    bit         l_we, l_err;
    logic [7:0] l_rd, e_rdata;
    bit         m_ack;
    logic       o_stall, o_err;
    logic [7:0] o_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called ~1ns after posedge with inputs applied; checks at negedge, then advances.
    task automatic step();
        bit         sfr, e_stall, e_we, e_err;
        logic [15:0] e_ra, e_wa;
        logic [7:0]  e_di;
        @(negedge clk);
        sfr = (dma_addr < 16'h0100) && (dma_addr >= 16'h0080);
        if (ph == 1) begin
            e_stall = 1; e_ra = dma_addr; e_wa = dma_addr; e_di = dma_wdata;
            e_we = dma_we && !sfr;
        end else begin
            e_stall = 0; e_ra = cpu_read_addr; e_wa = cpu_write_addr; e_di = cpu_data_in;
            e_we = cpu_we;
        end
        m_ack = (ph == 2);
        e_err = m_ack && l_err;
        if (m_ack && !l_we && !l_err) e_rdata = l_rd;
        chk("stall", cpu_stall, e_stall);
        chk("ack", dma_ack, m_ack);
        chk("err", dma_err, e_err);
        chk("rdata", dma_rdata, e_rdata);
        chk("mem_we", mem_we, e_we);
        chk("mem_raddr", mem_read_addr, e_ra);
        if (e_we) begin
            chk("mem_waddr", mem_write_addr, e_wa);
            chk("mem_wdata", mem_data_in, e_di);
        end
        o_stall = cpu_stall; o_err = dma_err; o_rdata = dma_rdata;
        case (ph)
            0: if (dma_req && ((!cpu_re && !cpu_we) || wcnt == MAX_WAIT)) ph = 1;
               else if (dma_req && wcnt < 15) wcnt++;
            1: begin
                l_we = dma_we; l_err = sfr; l_rd = ref_mem[dma_addr];
                wcnt = 0; ph = 2;
            end
            default: ph = 0;
        endcase
        if (e_we) ref_mem[e_wa] = e_di;
        @(posedge clk); #1;
    endtask

    // cpu_mode: 0 idle, 1 continuous reads, 2 random traffic
    task automatic set_cpu(input int cpu_mode);
        cpu_read_addr  = 16'($urandom);
        cpu_write_addr = 16'($urandom);
        cpu_data_in    = 8'($urandom);
        cpu_re = (cpu_mode == 1) || (cpu_mode == 2 && $urandom_range(0, 1) == 1);
        cpu_we = (cpu_mode == 2 && $urandom_range(0, 3) == 0);
    endtask

    task automatic dma_xfer(input bit we, input logic [15:0] addr, input logic [7:0] data,
                            input int cpu_mode, output int ack_cyc, output int stalls);
        ack_cyc = -1; stalls = 0;
        dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = data;
        for (int k = 0; k < 40; k++) begin
            set_cpu(cpu_mode);
            step();
            if (o_stall) stalls++;
            if (m_ack) begin ack_cyc = k; break; end
        end
        if (ack_cyc < 0) chk("ack_timeout", 0, 1);
        dma_req = 0;
    endtask

    int ac, st;
    logic [7:0] sfr_orig;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i] = 8'($urandom); ref_mem[i] = tb_mem[i];
        end
        tb_mem[16'h1234] = 8'h3C; ref_mem[16'h1234] = 8'h3C;
        e_rdata = 8'h00;
        reset_n = 0; dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        set_cpu(0); cpu_we = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_ack", dma_ack, 0);
        chk("rst_err", dma_err, 0);
        chk("rst_rdata", dma_rdata, 8'h00);
        chk("rst_mem_we", mem_we, 0);
        @(posedge clk); #1;
        cpu_we = 0; reset_n = 1;

        // write then read back, CPU idle
        dma_xfer(1, 16'h0040, 8'hA5, 0, ac, st);
        chk("wr_ack_cyc", ac, 2);
        chk("wr_err", o_err, 0);
        dma_xfer(0, 16'h0040, 8'h00, 0, ac, st);
        chk("rd_back", o_rdata, 8'hA5);

        // starvation: CPU reading every cycle
        dma_xfer(1, 16'h0200, 8'h11, 1, ac, st);
        chk("starve_ack_cyc", ac, MAX_WAIT + 2);
        chk("starve_stalls", st, 1);

        // SFR write rejected
        sfr_orig = tb_mem[16'h0090];
        dma_xfer(1, 16'h0090, 8'h5A, 0, ac, st);
        chk("sfr_err", o_err, 1);
        set_cpu(0); step();
        chk("sfr_untouched", tb_mem[16'h0090], sfr_orig);

        // XRAM read of preloaded location
        dma_xfer(0, 16'h1234, 8'h00, 0, ac, st);
        chk("xram_rd", o_rdata, 8'h3C);
        chk("xram_err", o_err, 0);

        // back-to-back requests, CPU idle
        for (int i = 0; i < 3; i++) begin
            dma_xfer(i[0], 16'h0300 + 16'(i), 8'(i), 0, ac, st);
            chk("b2b_spacing", ac, 2);
            chk("b2b_wait_cnt", dut.wait_cnt, 0);
        end

        // reset in the middle of a DMA access
        dma_req = 1; dma_we = 1; dma_addr = 16'h0050; dma_wdata = 8'h77;
        set_cpu(0); step();
        #2 reset_n = 0; dma_req = 0;
        #1;
        chk("mid_rst_stall", cpu_stall, 0);
        chk("mid_rst_ack", dma_ack, 0);
        chk("mid_rst_err", dma_err, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        ph = 0; wcnt = 0; e_rdata = 8'h00;
        @(posedge clk); #1;
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin set_cpu(0); step(); end

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0: a = 16'h0080 + 16'($urandom_range(0, 127));
                1: a = 16'($urandom_range(0, 127));
                default: a = 16'($urandom);
            endcase
            dma_xfer($urandom_range(0, 1) == 1, a, 8'($urandom), $urandom_range(0, 2), ac, st);
            repeat ($urandom_range(0, 3)) begin set_cpu(2); step(); end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end
endmodule
